// File: rtl/x_delay_line_pkg.sv
// Shared defaults and types for the delay-line measurement block.
package x_delay_line_pkg;

    localparam int DW_DEF       = 32;
    localparam int WIN_LOG2_DEF = 4;
    localparam int POSW_DEF     = $clog2(DW_DEF + 1);

    typedef logic [POSW_DEF-1:0] pos_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/x_dl_edge_find.sv
// Edge position finder: count of contiguous taps from bit 0 equal to bit 0, registered.
// X_DL_MEAS_BUBBLE_FIX_EN enables a 3-tap majority filter on interior taps ahead of the search.
module x_dl_edge_find
    import x_delay_line_pkg::*;
#(
    parameter int  DW   = DW_DEF,
    localparam int POSW = $clog2(DW + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [DW-1:0]   i_data,
    output logic [POSW-1:0] o_pos
);

    logic [DW-1:0]   taps;
    logic [POSW-1:0] pos_c;

`ifdef X_DL_MEAS_BUBBLE_FIX_EN
    always_comb begin
        taps = i_data;
        for (int i = 1; i < DW - 1; i++) begin
            taps[i] = (i_data[i-1] & i_data[i]) | (i_data[i-1] & i_data[i+1]) |
                      (i_data[i] & i_data[i+1]);
        end
    end
`else
    assign taps = i_data;
`endif

    // Descending scan so the lowest differing tap wins; no difference means DW.
    always_comb begin
        pos_c = POSW'(DW);
        for (int i = DW - 1; i >= 1; i--) begin
            if (taps[i] != taps[0]) pos_c = POSW'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_pos <= '0;
        else          o_pos <= pos_c;
    end

endmodule

// File: rtl/x_delay_line_meas.sv
// Delay-line window statistics: min/max/sum/avg/saturation of edge position over 2^WIN_LOG2 samples.
// Optional macro X_DL_MEAS_BUBBLE_FIX_EN (bubble filter inside x_dl_edge_find).
module x_delay_line_meas
    import x_delay_line_pkg::*;
#(
    parameter int  DW       = DW_DEF,
    parameter int  WIN_LOG2 = WIN_LOG2_DEF,
    localparam int POSW     = $clog2(DW + 1),
    localparam int SUMW     = POSW + WIN_LOG2,
    localparam int CNTW     = WIN_LOG2 + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [DW-1:0]   i_data,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [POSW-1:0] o_min,
    output logic [POSW-1:0] o_max,
    output logic [SUMW-1:0] o_sum,
    output logic [POSW-1:0] o_avg,
    output logic [CNTW-1:0] o_sat_cnt
);

    localparam logic [CNTW-1:0] CNT_N    = CNTW'(1 << WIN_LOG2);
    localparam logic [POSW-1:0] POS_FULL = POSW'(DW);

    state_t          state_q, state_d;
    logic            start_acc, smp_vld, pos_vld, last_upd;
    logic [CNTW-1:0] dcnt_q;
    logic [POSW-1:0] pos_q, min_q, max_q, min_nxt, max_nxt;
    logic [SUMW-1:0] sum_q, sum_nxt;
    logic [CNTW-1:0] sat_q, sat_nxt;

    x_dl_edge_find #(.DW(DW)) u_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .o_pos   (pos_q)
    );

    always_comb begin
        sum_nxt = sum_q + SUMW'(pos_q);
        min_nxt = (pos_q < min_q) ? pos_q : min_q;
        max_nxt = (pos_q > max_q) ? pos_q : max_q;
        sat_nxt = sat_q + CNTW'(pos_q == POS_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // smp_vld marks cycles whose i_data is a window sample; pos_vld trails it by the edge-find register.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        smp_vld   = 1'b0;
        last_upd  = 1'b0;
        o_busy    = 1'b0;
        o_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                o_busy   = 1'b1;
                smp_vld  = (dcnt_q != CNT_N);
                last_upd = pos_vld && !smp_vld;
                if (last_upd) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    start_acc = i_start;
                    state_d   = i_start ? ST_ACCUM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pos_vld   <= 1'b0;
            dcnt_q    <= '0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            sat_q     <= '0;
            o_min     <= '0;
            o_max     <= '0;
            o_sum     <= '0;
            o_avg     <= '0;
            o_sat_cnt <= '0;
        end else begin
            pos_vld <= smp_vld;
            if (start_acc) begin
                dcnt_q <= '0;
                sum_q  <= '0;
                min_q  <= POS_FULL;
                max_q  <= '0;
                sat_q  <= '0;
            end else begin
                if (smp_vld) dcnt_q <= dcnt_q + 1'b1;
                if (pos_vld) begin
                    sum_q <= sum_nxt;
                    min_q <= min_nxt;
                    max_q <= max_nxt;
                    sat_q <= sat_nxt;
                end
            end
            // Results publish only on the final update, so they stay stable through DONE and beyond.
            if (last_upd) begin
                o_min     <= min_nxt;
                o_max     <= max_nxt;
                o_sum     <= sum_nxt;
                o_avg     <= POSW'(sum_nxt >> WIN_LOG2);
                o_sat_cnt <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_x_delay_line_meas.sv
// Randomized self-checking bench for x_delay_line_meas against a window-statistics model.
module tb_x_delay_line_meas;

    localparam int N = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_start = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_busy, o_valid;
    logic [5:0]  o_min, o_max, o_avg;
    logic [9:0]  o_sum;
    logic [4:0]  o_sat_cnt;

    int checks = 0;
    int errors = 0;
    int e_min, e_max, e_sum, e_sat;

    x_delay_line_meas dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_data    (i_data),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_min     (o_min),
        .o_max     (o_max),
        .o_sum     (o_sum),
        .o_avg     (o_avg),
        .o_sat_cnt (o_sat_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge position straight from the rule: first tap differing from tap 0, else 32.
    function automatic int ref_pos(input logic [31:0] d);
        logic [31:0] t;
        t = d;
`ifdef X_DL_MEAS_BUBBLE_FIX_EN
        for (int i = 1; i < 31; i++)
            t[i] = (int'(d[i-1]) + int'(d[i]) + int'(d[i+1])) >= 2;
`endif
        for (int i = 1; i < 32; i++)
            if (t[i] != t[0]) return i;
        return 32;
    endfunction

    function automatic logic [31:0] gen(input int mode, input int k);
        logic [31:0] d;
        logic        b0;
        int          p;
        case (mode)
            0:       d = 32'h0000_00FF;
            1:       d = (k % 2 == 1) ? 32'h0000_00FF : 32'hFFFF_FF00;
            2:       d = 32'hFFFF_FFFF;
            3:       d = 32'h0000_00F7;
            default: begin
                b0 = 1'($urandom);
                p  = int'($urandom_range(1, 32));
                d  = $urandom;
                for (int i = 0; i < 32; i++) if (i < p) d[i] = b0;
                if (p < 32) d[p] = ~b0;
                if ($urandom_range(0, 3) == 0) begin
                    p = int'($urandom_range(1, 30));
                    d[p] = ~d[p];
                end
            end
        endcase
        return d;
    endfunction

    // Starts a window (accepting any pending result in the same cycle) and checks its result.
    task automatic do_window(input int mode);
        logic [31:0] d;
        int          p, lat;
        e_min = 32; e_max = 0; e_sum = 0; e_sat = 0;
        i_start = 1'b1; i_ready = 1'b1; i_data = $urandom;
        @(negedge i_clk);
        i_start = 1'b0; i_ready = 1'b0; lat = 1;
        chk("start_busy", int'(o_busy), 1);
        chk("start_valid_low", int'(o_valid), 0);
        for (int k = 1; k <= N; k++) begin
            d = gen(mode, k);
            i_data = d;
            p = ref_pos(d);
            e_sum += p;
            if (p < e_min) e_min = p;
            if (p > e_max) e_max = p;
            if (p == 32) e_sat++;
            @(negedge i_clk);
            lat++;
        end
        chk("early_valid", int'(o_valid), 0);
        i_data = $urandom;
        while (!o_valid && lat < N + 20) begin
            @(negedge i_clk);
            lat++;
            i_data = $urandom;
        end
        chk("latency", lat, N + 2);
        chk("min", int'(o_min), e_min);
        chk("max", int'(o_max), e_max);
        chk("sum", int'(o_sum), e_sum);
        chk("avg", int'(o_avg), e_sum / N);
        chk("sat", int'(o_sat_cnt), e_sat);
        chk("done_busy", int'(o_busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_min"}, int'(o_min), 0);
        chk({tag, "_max"}, int'(o_max), 0);
        chk({tag, "_sum"}, int'(o_sum), 0);
        chk({tag, "_avg"}, int'(o_avg), 0);
        chk({tag, "_sat"}, int'(o_sat_cnt), 0);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk_zero("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        do_window(0);
        chk("ff_sum", int'(o_sum), 128);
        chk("ff_minmax", int'(o_min) + int'(o_max), 16);
        do_window(1);
        chk("alt_sum", int'(o_sum), 128);
        chk("alt_avg", int'(o_avg), 8);
        do_window(2);
        chk("ones_sum", int'(o_sum), 512);
        chk("ones_sat", int'(o_sat_cnt), 16);
        do_window(3);
`ifdef X_DL_MEAS_BUBBLE_FIX_EN
        chk("bubble_sum", int'(o_sum), 128);
`else
        chk("bubble_sum", int'(o_sum), 48);
`endif

        // Backpressure: result held, starts ignored without ready.
        for (int c = 0; c < 5; c++) begin
            i_ready = 1'b0;
            i_start = (c % 2 == 0);
            i_data = $urandom;
            @(negedge i_clk);
            chk("bp_valid", int'(o_valid), 1);
            chk("bp_busy", int'(o_busy), 0);
            chk("bp_sum", int'(o_sum), e_sum);
            chk("bp_min", int'(o_min), e_min);
        end
        i_start = 1'b0;
        do_window(4);

        // Plain accept returns to IDLE with results held.
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("acc_valid", int'(o_valid), 0);
        chk("acc_busy", int'(o_busy), 0);
        chk("acc_sum_held", int'(o_sum), e_sum);
        @(negedge i_clk);
        chk("idle_busy", int'(o_busy), 0);

        // Reset in the middle of a window.
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 1; k < 7; k++) begin
            i_data = $urandom;
            @(negedge i_clk);
        end
        i_rst_n = 1'b0;
        i_data = $urandom;
        @(negedge i_clk);
        chk_zero("midrst");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_idle", int'(o_busy), 0);
        do_window(4);

        for (int w = 0; w < 8; w++) do_window(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
